// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the serial add/subtract unit:
//     - state_t : FSM encoding (IDLE=0, RUN=1, DONE=2; the code 3 is unused
//                 and recovers to IDLE)
//     - clog2   : ceiling log2, used to size the slice counter
//   No ports.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 for value >= 1; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// fa_slice
//   Combinational ripple chain of W full-adder cells. This is the only
//   arithmetic in the serial adder; the top level iterates it over the
//   operand one slice per cycle.
// Ports
//   a, b  in  W   slice operands (LSB aligned)
//   cin   in  1   carry into bit 0 of the slice
//   s     out W   slice sum
//   cout  out 1   carry out of bit W-1
//   cmsb  out 1   carry into bit W-1 (needed for signed overflow on the
//                 last slice of the word)
module fa_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  // c[i] is the carry into bit i; c[W] is the carry out of the slice.
  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];
  assign cmsb = c[W - 1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle add/subtract unit. A BITS_PER_CYCLE-wide ripple slice is
//   applied LSB-first over WIDTH bits, N = WIDTH / BITS_PER_CYCLE cycles per
//   operation. Subtraction is done as a + ~b + ~cin, so carry = 1 means
//   "no borrow" for subtracts.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both 1. in_ready is high only in IDLE (and not during rst);
//   out_valid stays high, with sum/carry/overflow frozen, until out_ready
//   is seen. Neither side queues: in_valid outside IDLE is ignored.
//
//   Timing: out_valid rises N cycles after the accept edge; with out_ready
//   held high a new operation can start every N+2 cycles.
//
// Parameters
//   WIDTH           operand/result width, >= 1
//   BITS_PER_CYCLE  slice width; must divide WIDTH
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high; aborts any op
//   in_valid   in   1      operands present
//   in_ready   out  1      unit can accept operands (IDLE and not in reset)
//   a, b       in   WIDTH  operands, sampled only on the accept edge
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin   1: a-b-cin
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result, registered
//   carry      out  1      carry-out of the chain
//   overflow   out  1      signed overflow (carry into MSB ^ carry out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  // Keep the counter at least one bit wide so N == 1 still elaborates.
  localparam int CW = (N > 1) ? clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
  end

  // ---------------------------------------------------------------------
  // State and working registers
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;      // remaining bits of a, consumed from the LSB
  logic [WIDTH-1:0] b_sh;      // remaining bits of b (already inverted for sub)
  logic [WIDTH-1:0] res_sh;    // partial result, filled from the MSB side
  logic             carry_r;   // carry between slices
  logic [CW-1:0]    count;     // index of the slice being processed

  logic accept;
  logic last_slice;

  // Slice datapath
  logic [BITS_PER_CYCLE-1:0] sl_s;
  logic                      sl_cout;
  logic                      sl_cmsb;
  logic [WIDTH-1:0]          slice_ext;
  logic [WIDTH-1:0]          res_next;

  fa_slice #(
    .W (BITS_PER_CYCLE)
  ) u_slice (
    .a    (a_sh[BITS_PER_CYCLE-1:0]),
    .b    (b_sh[BITS_PER_CYCLE-1:0]),
    .cin  (carry_r),
    .s    (sl_s),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  // After N shifts the first slice has travelled down to bit 0, so the
  // result ends up LSB-aligned without a final realignment step.
  assign slice_ext = WIDTH'(sl_s) << (WIDTH - BITS_PER_CYCLE);
  assign res_next  = (res_sh >> BITS_PER_CYCLE) | slice_ext;

  assign in_ready   = (state == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_slice = (state == ST_RUN) && (count == LAST);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count == LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_r <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= sub ? ~b : b;
      carry_r <= sub ? ~cin : cin;
      res_sh  <= '0;
      count   <= '0;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> BITS_PER_CYCLE;
      b_sh    <= b_sh >> BITS_PER_CYCLE;
      res_sh  <= res_next;
      carry_r <= sl_cout;
      count   <= count + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Output registers: loaded only on the last slice, cleared only by rst.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (last_slice) begin
      sum       <= res_next;
      carry     <= sl_cout;
      overflow  <= sl_cmsb ^ sl_cout;
      out_valid <= 1'b1;
    end else if (state == ST_DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed checks of an 8-bit/1-bit-per-cycle instance (latency, add and
//   subtract corner values, backpressure, reset abort) and a 16-bit/4-bit
//   instance exercised with an operand table plus random operands and
//   random output stalls against an integer reference.
module tb_serial_adder;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------
  // DUT 8-bit, 1 bit per cycle
  // ---------------------------------------------------------------------
  logic       d8_in_valid, d8_in_ready, d8_cin, d8_sub;
  logic       d8_out_valid, d8_out_ready, d8_carry, d8_overflow;
  logic [7:0] d8_a, d8_b, d8_sum;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d8_in_valid),
    .in_ready  (d8_in_ready),
    .a         (d8_a),
    .b         (d8_b),
    .cin       (d8_cin),
    .sub       (d8_sub),
    .out_valid (d8_out_valid),
    .out_ready (d8_out_ready),
    .sum       (d8_sum),
    .carry     (d8_carry),
    .overflow  (d8_overflow)
  );

  // ---------------------------------------------------------------------
  // DUT 16-bit, 4 bits per cycle
  // ---------------------------------------------------------------------
  logic        d16_in_valid, d16_in_ready, d16_cin, d16_sub;
  logic        d16_out_valid, d16_out_ready, d16_carry, d16_overflow;
  logic [15:0] d16_a, d16_b, d16_sum;

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d16_in_valid),
    .in_ready  (d16_in_ready),
    .a         (d16_a),
    .b         (d16_b),
    .cin       (d16_cin),
    .sub       (d16_sub),
    .out_valid (d16_out_valid),
    .out_ready (d16_out_ready),
    .sum       (d16_sum),
    .carry     (d16_carry),
    .overflow  (d16_overflow)
  );

  // ---------------------------------------------------------------------
  // Driver tasks (all start and end just after a falling edge)
  // ---------------------------------------------------------------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int guard;
    guard = 0;
    d8_a = a; d8_b = b; d8_cin = cin; d8_sub = sub; d8_in_valid = 1'b1;
    while (!d8_in_ready && guard < 50) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      $display("FAIL send8_accept_timeout got=in_ready_low exp=in_ready_high");
      bad++; total++;
    end
    @(posedge clk);
    @(negedge clk);
    d8_in_valid = 1'b0;
    d8_a = 8'h00; d8_b = 8'h00; d8_cin = 1'b0; d8_sub = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait8(output int lat);
    lat = 0;
    while (!d8_out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  task automatic take8;
    d8_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    d8_out_ready = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int guard;
    guard = 0;
    d16_a = a; d16_b = b; d16_cin = cin; d16_sub = sub; d16_in_valid = 1'b1;
    while (!d16_in_ready && guard < 50) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      $display("FAIL send16_accept_timeout got=in_ready_low exp=in_ready_high");
      bad++; total++;
    end
    @(posedge clk);
    @(negedge clk);
    d16_in_valid = 1'b0;
    d16_a = 16'h0000; d16_b = 16'h0000; d16_cin = 1'b0; d16_sub = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (!d16_out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  task automatic take16;
    d16_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    d16_out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset;
    if (d8_in_ready !== 1'b0) begin $display("FAIL rst_in_ready8 got=%b exp=0", d8_in_ready); bad++; end
    total++;
    if (d8_out_valid !== 1'b0) begin $display("FAIL rst_out_valid8 got=%b exp=0", d8_out_valid); bad++; end
    total++;
    if (d8_sum !== 8'h00) begin $display("FAIL rst_sum8 got=%h exp=00", d8_sum); bad++; end
    total++;
    if (d8_carry !== 1'b0 || d8_overflow !== 1'b0) begin
      $display("FAIL rst_flags8 got=%b%b exp=00", d8_carry, d8_overflow); bad++;
    end
    total++;
    if (d16_in_ready !== 1'b0 || d16_out_valid !== 1'b0 || d16_sum !== 16'h0000) begin
      $display("FAIL rst_dut16 got=%b/%b/%h exp=0/0/0000", d16_in_ready, d16_out_valid, d16_sum); bad++;
    end
    total++;
    rst = 1'b0;
    #1;
    if (d8_in_ready !== 1'b1 || d16_in_ready !== 1'b1) begin
      $display("FAIL rst_release_in_ready got=%b%b exp=11", d8_in_ready, d16_in_ready); bad++;
    end
    total++;
    @(negedge clk);
  endtask

  task automatic test_add_basic;
    int lat;
    send8(8'h0F, 8'h01, 1'b0, 1'b0);
    wait8(lat);
    if (lat !== 8) begin $display("FAIL add_basic_latency got=%0d exp=8", lat); bad++; end
    total++;
    if (d8_sum !== 8'h10 || d8_carry !== 1'b0 || d8_overflow !== 1'b0) begin
      $display("FAIL add_basic got=%h c=%b v=%b exp=10 c=0 v=0", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
    if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1) begin
      $display("FAIL add_basic_handshake got=ov%b ir%b exp=ov0 ir1", d8_out_valid, d8_in_ready); bad++;
    end
    total++;
  endtask

  task automatic test_add_edges;
    int lat;
    send8(8'hFF, 8'h01, 1'b1, 1'b0);
    wait8(lat);
    if (d8_sum !== 8'h01 || d8_carry !== 1'b1 || d8_overflow !== 1'b0) begin
      $display("FAIL add_wrap got=%h c=%b v=%b exp=01 c=1 v=0", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8(lat);
    if (d8_sum !== 8'h80 || d8_carry !== 1'b0 || d8_overflow !== 1'b1) begin
      $display("FAIL add_ovf got=%h c=%b v=%b exp=80 c=0 v=1", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
  endtask

  task automatic test_sub;
    int lat;
    send8(8'h05, 8'h07, 1'b0, 1'b1);
    wait8(lat);
    if (d8_sum !== 8'hFE || d8_carry !== 1'b0 || d8_overflow !== 1'b0) begin
      $display("FAIL sub_borrow got=%h c=%b v=%b exp=FE c=0 v=0", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
    send8(8'h80, 8'h01, 1'b0, 1'b1);
    wait8(lat);
    if (d8_sum !== 8'h7F || d8_carry !== 1'b1 || d8_overflow !== 1'b1) begin
      $display("FAIL sub_ovf got=%h c=%b v=%b exp=7F c=1 v=1", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
    // 0x10 - 0x03 - borrow 1 = 0x0C, no borrow out
    send8(8'h10, 8'h03, 1'b1, 1'b1);
    wait8(lat);
    if (d8_sum !== 8'h0C || d8_carry !== 1'b1 || d8_overflow !== 1'b0) begin
      $display("FAIL sub_borrow_in got=%h c=%b v=%b exp=0C c=1 v=0", d8_sum, d8_carry, d8_overflow); bad++;
    end
    total++;
    take8();
  endtask

  task automatic test_backpressure;
    int lat;
    send8(8'h21, 8'h13, 1'b0, 1'b0);
    wait8(lat);
    if (lat !== 8) begin $display("FAIL bp_latency got=%0d exp=8", lat); bad++; end
    total++;
    for (int i = 0; i < 5; i++) begin
      d8_in_valid = (i % 2 == 0);
      d8_a = 8'hAA; d8_b = 8'h55; d8_cin = 1'b1; d8_sub = 1'b1;
      @(posedge clk); @(negedge clk);
      if (d8_sum !== 8'h34 || d8_carry !== 1'b0 || d8_overflow !== 1'b0 || d8_out_valid !== 1'b1) begin
        $display("FAIL bp_hold cycle=%0d got=%h c=%b v=%b ov=%b exp=34 c=0 v=0 ov=1",
                 i, d8_sum, d8_carry, d8_overflow, d8_out_valid);
        bad++;
      end
      total++;
      if (d8_in_ready !== 1'b0) begin $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, d8_in_ready); bad++; end
      total++;
    end
    // Handshake cycle: new operands already offered, but not yet acceptable.
    d8_a = 8'h03; d8_b = 8'h04; d8_cin = 1'b0; d8_sub = 1'b0; d8_in_valid = 1'b1;
    d8_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    d8_out_ready = 1'b0;
    if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1) begin
      $display("FAIL bp_after_handshake got=ov%b ir%b exp=ov0 ir1", d8_out_valid, d8_in_ready); bad++;
    end
    total++;
    @(posedge clk); @(negedge clk);
    d8_in_valid = 1'b0;
    d8_a = 8'h00; d8_b = 8'h00;
    if (d8_in_ready !== 1'b0) begin $display("FAIL bp_second_accept got=in_ready%b exp=0", d8_in_ready); bad++; end
    total++;
    wait8(lat);
    if (lat !== 8 || d8_sum !== 8'h07) begin
      $display("FAIL bp_second_result got=lat%0d sum=%h exp=lat8 sum=07", lat, d8_sum); bad++;
    end
    total++;
    take8();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic seen;
    send8(8'h40, 8'h40, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    if (d8_out_valid !== 1'b0 || d8_sum !== 8'h00 || d8_carry !== 1'b0) begin
      $display("FAIL midrst_clear got=ov%b sum=%h c=%b exp=ov0 sum=00 c=0", d8_out_valid, d8_sum, d8_carry); bad++;
    end
    total++;
    if (d8_in_ready !== 1'b0) begin $display("FAIL midrst_in_ready_during got=%b exp=0", d8_in_ready); bad++; end
    total++;
    rst = 1'b0;
    #1;
    if (d8_in_ready !== 1'b1) begin $display("FAIL midrst_in_ready_after got=%b exp=1", d8_in_ready); bad++; end
    total++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (d8_out_valid) seen = 1'b1;
    end
    if (seen !== 1'b0) begin $display("FAIL midrst_aborted got=result_seen exp=no_result"); bad++; end
    total++;
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8(lat);
    if (lat !== 8 || d8_sum !== 8'h46 || d8_carry !== 1'b0) begin
      $display("FAIL midrst_next_op got=lat%0d sum=%h c=%b exp=lat8 sum=46 c=0", lat, d8_sum, d8_carry); bad++;
    end
    total++;
    take8();
  endtask

  task automatic test_wide16;
    logic [15:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [15:0] tb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
    logic        tc[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] a, b, exp_sum;
    logic        cin, sub, exp_carry, exp_ovf;
    int          lat, ua, ub, sa, sb, r, stall;
    for (int i = 0; i < 1004; i++) begin
      if (i < 4) begin
        a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i];
      end else begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
      ua = int'(a); ub = int'(b);
      sa = $signed(a); sb = $signed(b);
      if (!sub) begin
        exp_sum   = 16'(ua + ub + int'(cin));
        exp_carry = (ua + ub + int'(cin)) >= 65536;
        r         = sa + sb + int'(cin);
      end else begin
        exp_sum   = 16'(ua - ub - int'(cin));
        exp_carry = (ua - ub - int'(cin)) >= 0;
        r         = sa - sb - int'(cin);
      end
      exp_ovf = (r > 32767) || (r < -32768);

      send16(a, b, cin, sub);
      wait16(lat);
      if (lat !== 4) begin $display("FAIL w16_latency op=%0d got=%0d exp=4", i, lat); bad++; end
      total++;
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        d16_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
      end
      d16_in_valid = 1'b0;
      if (d16_out_valid !== 1'b1 || d16_sum !== exp_sum) begin
        $display("FAIL w16_sum op=%0d a=%h b=%h cin=%b sub=%b got=%h ov=%b exp=%h ov=1",
                 i, a, b, cin, sub, d16_sum, d16_out_valid, exp_sum);
        bad++;
      end
      total++;
      if (d16_carry !== exp_carry || d16_overflow !== exp_ovf) begin
        $display("FAIL w16_flags op=%0d a=%h b=%h cin=%b sub=%b got=c%b v%b exp=c%b v%b",
                 i, a, b, cin, sub, d16_carry, d16_overflow, exp_carry, exp_ovf);
        bad++;
      end
      total++;
      take16();
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    d8_in_valid = 1'b0; d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0; d8_out_ready = 1'b0;
    d16_in_valid = 1'b0; d16_a = '0; d16_b = '0; d16_cin = 1'b0; d16_sub = 1'b0; d16_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_wide16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
